// File: rtl/bcm_pkg.sv
// Shared types and helpers for the bcm code-mapping lookup and its scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcm_pkg;

  // Occupancy of the scheduler's single response register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int BCM_DW = 3;  // lookup input code width
  localparam int BCM_OW = 2;  // lookup result width

  // Reference form of the 3-bit to 2-bit mapping table.
  function automatic logic [BCM_OW-1:0] bcm_map(input logic [BCM_DW-1:0] d);
    logic [BCM_OW-1:0] o;
    case (d)
      3'd0:    o = 2'b01;
      3'd1:    o = 2'b11;
      3'd2:    o = 2'b00;
      3'd3:    o = 2'b10;
      3'd4:    o = 2'b01;
      3'd5:    o = 2'b10;
      3'd6:    o = 2'b11;
      default: o = 2'b01;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bcm.sv
// Purpose: 3-bit to 2-bit code-mapping lookup shared by all requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the input code directly.
module bcm
  import bcm_pkg::*;
(
  input  logic [BCM_DW-1:0] d,
  output logic [BCM_OW-1:0] o
);

  // Fixed mapping table.
  always_comb begin
    o = 2'b01;
    case (d)
      3'd0:    o = 2'b01;
      3'd1:    o = 2'b11;
      3'd2:    o = 2'b00;
      3'd3:    o = 2'b10;
      3'd4:    o = 2'b01;
      3'd5:    o = 2'b10;
      3'd6:    o = 2'b11;
      3'd7:    o = 2'b01;
      default: o = 2'b01;
    endcase
  end

endmodule

// File: rtl/bcm_sched_rr_arb.sv
// Purpose: round-robin pick of the first set request at or after ptr, wrapping N-1 -> 0.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller gates the grant with its own enable.
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Search ascending from ptr; the wrap is done against N explicitly so a
  // non-power-of-two N never relies on IDW overflow.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) begin
        sum = sum - (IDW+1)'(N);
      end
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Expand the winner to one-hot; all zeros when nothing is requesting.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = found && (gnt_idx == IDW'(i));
    end
  end

endmodule

// File: rtl/bcm_sched.sv
// Purpose: round-robin share of one bcm lookup among N requesters; BCM_SCHED_STATS_EN adds served/stall counters.
// Latency: 1 cycle from request accept to rsp_valid; 1 response per cycle sustained.
// Backpressure: rsp_ready low while full holds the response and drops every req_ready.
module bcm_sched
  import bcm_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  input  logic [BCM_DW*N-1:0]   req_d,
  output logic [N-1:0]          req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BCM_OW-1:0]     rsp_o,
  output logic [IDW-1:0]        rsp_id
`ifdef BCM_SCHED_STATS_EN
  ,
  output logic [15:0]           served_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [BCM_OW-1:0] rsp_o_q, rsp_o_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;

  logic              out_free;
  logic              xfer;
  logic [N-1:0]      gnt;
  logic [IDW-1:0]    gnt_idx;
  logic [BCM_DW-1:0] code_sel;
  logic [BCM_OW-1:0] map_o;

  // Arbitration looks only at the valids, so req_ready never depends on req_d.
  rr_arb #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant only when the response register is free or being drained this cycle.
  always_comb begin
    req_ready = out_free ? gnt : '0;
    xfer      = |(req_valid & req_ready);
  end

  // Route the granted requester's code to the single lookup.
  always_comb begin
    code_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        code_sel = req_d[BCM_DW*i +: BCM_DW];
      end
    end
  end

  bcm u_bcm (
    .d (code_sel),
    .o (map_o)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a transfer always fills; a drain without a transfer empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (xfer) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (xfer) begin
          state_d = FULL;
        end else if (rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // FSM outputs: grant enable and response valid.
  always_comb begin
    out_free  = (state_q == EMPTY) || ((state_q == FULL) && rsp_ready);
    rsp_valid = (state_q == FULL);
  end

  // Datapath next state: result, id and pointer change only on a transfer.
  always_comb begin
    rsp_o_d  = rsp_o_q;
    rsp_id_d = rsp_id_q;
    ptr_d    = ptr_q;
    if (xfer) begin
      rsp_o_d  = map_o;
      rsp_id_d = gnt_idx;
      ptr_d    = (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_o_q  <= '0;
      rsp_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      rsp_o_q  <= rsp_o_d;
      rsp_id_q <= rsp_id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign rsp_o  = rsp_o_q;
  assign rsp_id = rsp_id_q;

`ifdef BCM_SCHED_STATS_EN
  logic [15:0] served_q, served_d;
  logic [15:0] stall_q, stall_d;

  // Served count wraps; stall count saturates so a long stall stays visible.
  always_comb begin
    served_d = served_q;
    stall_d  = stall_q;
    if (xfer) begin
      served_d = served_q + 16'd1;
    end
    if ((state_q == FULL) && !rsp_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      served_q <= '0;
      stall_q  <= '0;
    end else begin
      served_q <= served_d;
      stall_q  <= stall_d;
    end
  end

  assign served_cnt = served_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_bcm_sched.sv
// Testbench for bcm_sched with N=4: directed vector table, map sweep, random run vs model.
// Latency checked: outputs sampled 1 time unit after each rising edge.
// Backpressure: rsp_ready driven from the table and randomly.
module tb_bcm_sched;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [3*N-1:0]    req_d;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_o;
  logic [IDW-1:0]    rsp_id;
`ifdef BCM_SCHED_STATS_EN
  logic [15:0]       served_cnt;
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  bcm_sched #(.N(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_d      (req_d),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_o      (rsp_o),
    .rsp_id     (rsp_id)
`ifdef BCM_SCHED_STATS_EN
    ,
    .served_cnt (served_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Mapping written out independently of the RTL.
  localparam logic [1:0] MAP [8] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01};

  // Behavioural model of the scheduler.
  int       m_ptr;
  bit       m_full;
  int       m_o;
  int       m_id;
  int       m_served;
  int       m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int code_of(input logic [3*N-1:0] d, input int i);
    logic [3*N-1:0] t;
    t = d >> (3 * i);
    return int'(t[2:0]);
  endfunction

  function automatic int m_winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready(input logic [N-1:0] v, input logic rdy);
    int w;
    w = m_winner(v);
    if ((!m_full || rdy) && w >= 0) return N'(1) << w;
    return '0;
  endfunction

  task automatic model_edge(input logic rst, input logic [N-1:0] v, input logic [3*N-1:0] d,
                            input logic rdy);
    bit was_full;
    int w;
    if (rst) begin
      m_ptr = 0; m_full = 0; m_o = 0; m_id = 0; m_served = 0; m_stall = 0;
    end else begin
      was_full = m_full;
      w = m_winner(v);
      if ((!m_full || rdy) && w >= 0) begin
        m_o      = int'(MAP[code_of(d, w)]);
        m_id     = w;
        m_full   = 1;
        m_ptr    = (w + 1) % N;
        m_served = (m_served + 1) % 65536;
      end else if (m_full && rdy) begin
        m_full = 0;
      end
      if (was_full && !rdy && m_stall < 65535) m_stall++;
    end
  endtask

  // One clock: drive inputs, sample req_ready mid-cycle, clock, advance model.
  task automatic step(input logic rst, input logic [N-1:0] v, input logic [3*N-1:0] d,
                      input logic rdy, output logic [N-1:0] seen, output logic [N-1:0] exp_rdy);
    rst_n     = !rst;
    req_valid = v;
    req_d     = d;
    rsp_ready = rdy;
    #2;
    seen    = req_ready;
    exp_rdy = m_ready(v, rdy);
    @(posedge clk);
    model_edge(rst, v, d, rdy);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(m_full));
    check({tag, " rsp_o"},     32'(rsp_o),     32'(m_o));
    check({tag, " rsp_id"},    32'(rsp_id),    32'(m_id));
`ifdef BCM_SCHED_STATS_EN
    check({tag, " served_cnt"}, 32'(served_cnt), 32'(m_served));
    check({tag, " stall_cnt"},  32'(stall_cnt),  32'(m_stall));
`endif
  endtask

  typedef struct {
    logic           rst;
    logic [N-1:0]   v;
    logic [3*N-1:0] d;
    logic           rdy;
    logic [N-1:0]   er;
    logic           ev;
    logic [1:0]     eo;
    logic [1:0]     eid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [N-1:0] v, input logic [3*N-1:0] d,
                     input logic rdy, input logic [N-1:0] er, input logic ev,
                     input logic [1:0] eo, input logic [1:0] eid);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.rdy = rdy;
    t.er = er; t.ev = ev; t.eo = eo; t.eid = eid;
    tbl.push_back(t);
  endtask

  initial begin
    logic [N-1:0] seen, exp_rdy;

    // Single requester, code 1 -> 11, then drain.
    add(0, 4'b0001, 12'h001, 1, 4'b0001, 1, 2'b11, 2'd0);
    add(0, 4'b0000, 12'h001, 1, 4'b0000, 0, 2'b11, 2'd0);
    // Reset to put the pointer back at 0.
    add(1, 4'b0000, 12'h000, 1, 4'b0000, 0, 2'b00, 2'd0);
    // All four valid, codes 5,2,6,0 on requesters 0..3.
    add(0, 4'b1111, 12'h195, 1, 4'b0001, 1, 2'b10, 2'd0);
    add(0, 4'b1111, 12'h195, 1, 4'b0010, 1, 2'b00, 2'd1);
    add(0, 4'b1111, 12'h195, 1, 4'b0100, 1, 2'b11, 2'd2);
    add(0, 4'b1111, 12'h195, 1, 4'b1000, 1, 2'b01, 2'd3);
    add(0, 4'b1111, 12'h195, 1, 4'b0001, 1, 2'b10, 2'd0);
    // Backpressure for 3 cycles with requesters 1 and 2 valid, then release.
    add(0, 4'b0110, 12'h195, 0, 4'b0000, 1, 2'b10, 2'd0);
    add(0, 4'b0110, 12'h195, 0, 4'b0000, 1, 2'b10, 2'd0);
    add(0, 4'b0110, 12'h195, 0, 4'b0000, 1, 2'b10, 2'd0);
    add(0, 4'b0110, 12'h195, 1, 4'b0010, 1, 2'b00, 2'd1);
    add(0, 4'b0110, 12'h195, 1, 4'b0100, 1, 2'b11, 2'd2);
    // Wrap from ptr=3 with requesters 1 and 3 valid.
    add(0, 4'b1010, 12'h195, 1, 4'b1000, 1, 2'b01, 2'd3);
    add(0, 4'b1010, 12'h195, 1, 4'b0010, 1, 2'b00, 2'd1);
    // Idle cycles: drain, then nothing; ptr must stay at 2.
    add(0, 4'b0000, 12'h195, 1, 4'b0000, 0, 2'b00, 2'd1);
    add(0, 4'b0000, 12'h195, 0, 4'b0000, 0, 2'b00, 2'd1);
    add(0, 4'b0101, 12'h195, 1, 4'b0100, 1, 2'b11, 2'd2);
    // Reset mid-operation while holding 01; then requester 2 before 3.
    add(0, 4'b0001, 12'h7C0, 1, 4'b0001, 1, 2'b01, 2'd0);
    add(1, 4'b1100, 12'h7C0, 0, 4'b0000, 0, 2'b00, 2'd0);
    add(0, 4'b1100, 12'h7C0, 1, 4'b0100, 1, 2'b01, 2'd2);
    add(0, 4'b1100, 12'h7C0, 1, 4'b1000, 1, 2'b10, 2'd3);

    rst_n = 1'b0; req_valid = '0; req_d = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    step(1, '0, '0, 0, seen, exp_rdy);
    step(1, '0, '0, 0, seen, exp_rdy);

    // Reset state.
    rst_n = 1'b1;
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_o",     32'(rsp_o),     32'd0);
    check("reset rsp_id",    32'(rsp_id),    32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
`ifdef BCM_SCHED_STATS_EN
    check("reset served_cnt", 32'(served_cnt), 32'd0);
    check("reset stall_cnt",  32'(stall_cnt),  32'd0);
`endif

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rdy, seen, exp_rdy);
      if (!tbl[i].rst) check($sformatf("vec%0d req_ready", i), 32'(seen), 32'(tbl[i].er));
      check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d rsp_o", i),     32'(rsp_o),     32'(tbl[i].eo));
      check($sformatf("vec%0d rsp_id", i),    32'(rsp_id),    32'(tbl[i].eid));
    end

    // Requester 0 sweeps every code after a fresh reset.
    step(1, '0, '0, 1, seen, exp_rdy);
    for (int k = 0; k < 8; k++) begin
      logic [3*N-1:0] dk;
      dk = (3*N)'(k);
      step(0, 4'b0001, dk, 1, seen, exp_rdy);
      check($sformatf("sweep%0d req_ready", k), 32'(seen), 32'b0001);
      check($sformatf("sweep%0d rsp_o", k), 32'(rsp_o), 32'(MAP[k]));
      compare_model($sformatf("sweep%0d", k));
    end
`ifdef BCM_SCHED_STATS_EN
    check("sweep served_cnt", 32'(served_cnt), 32'd8);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic           r_rst, r_rdy;
      logic [N-1:0]   r_v;
      logic [3*N-1:0] r_d;
      r_rst = ($urandom_range(0, 49) == 0);
      r_v   = N'($urandom);
      r_d   = (3*N)'($urandom);
      r_rdy = ($urandom_range(0, 3) != 0);
      step(r_rst, r_v, r_d, r_rdy, seen, exp_rdy);
      if (!r_rst) check($sformatf("rand%0d req_ready", n), 32'(seen), 32'(exp_rdy));
      compare_model($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
